// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM controller front end: widths, reader-select
// encoding and the request bundle carried from requester to controller.
package bram_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int OUTST_W = 4;

  localparam logic SEL_DMA = 1'b0;
  localparam logic SEL_CPU = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bram_req_t;

endpackage

// File: rtl/bram_outst_cnt.sv
// Outstanding-read counter for one requester: +1 on an accepted read, -1 on a
// read return, saturating at MAX_OUTST and refusing to underflow.
module bram_outst_cnt
  import bram_pkg::*;
#(
  parameter int MAX_OUTST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [OUTST_W-1:0] cnt,
  output logic               full
);

  localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTST);

  logic dec_ok;
  // Sticky flag for a return that arrived with nothing outstanding; it has no
  // port and is only observed from simulation.
  logic err_underflow;

  assign dec_ok = dec && (cnt != '0);
  assign full   = (cnt == MAX_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      err_underflow <= 1'b0;
    end else begin
      err_underflow <= err_underflow || (dec && (cnt == '0));
      case ({inc, dec_ok})
        2'b10:   if (!full) cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of a single-port BRAM controller.
// Default: fixed CPU priority with DMA starvation override; define
// BRAM_ARB_RR_EN for round-robin arbitration instead.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int MAX_OUTST  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_gnt,
  input  logic               dma_req,
  input  logic               dma_wr,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [DATA_W-1:0]  dma_wdata,
  output logic               dma_gnt,
  input  logic               cpu_rvalid,
  input  logic               dma_rack,
  output logic               WR,
  output logic               In_valid,
  output logic [ADDR_W-1:0]  Addr,
  output logic [DATA_W-1:0]  Di,
  output logic               reader_sel,
  output logic [OUTST_W-1:0] cpu_outst,
  output logic [OUTST_W-1:0] dma_outst
);

  bram_req_t cpu_r;
  bram_req_t dma_r;
  bram_req_t req_q;
  logic      cpu_full;
  logic      dma_full;
  logic      cpu_elig;
  logic      dma_elig;
  logic      dma_turn;

  assign cpu_r = '{wr: cpu_wr, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_r = '{wr: dma_wr, addr: dma_addr, wdata: dma_wdata};

  // Writes never consume a read slot, so they bypass the outstanding cap.
  assign cpu_elig = cpu_req && (cpu_wr || !cpu_full);
  assign dma_elig = dma_req && (dma_wr || !dma_full);

`ifdef BRAM_ARB_RR_EN
  logic prio_q;  // requester that wins the next tie

  assign dma_turn = dma_elig && (prio_q == SEL_DMA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= SEL_CPU;
    end else if (cpu_gnt) begin
      prio_q <= SEL_DMA;
    end else if (dma_gnt) begin
      prio_q <= SEL_CPU;
    end
  end
`else
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  assign dma_turn = dma_elig && (starve_cnt == STARVE_LIM);

  // Counts consecutive cycles an eligible DMA lost to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (dma_gnt || !dma_elig) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both grants; no latch is inferred.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (cpu_elig && !dma_turn) begin
        cpu_gnt = 1'b1;
      end else if (dma_elig) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Granted request is presented to the controller one cycle later; the
  // payload holds its last value while In_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      In_valid   <= 1'b0;
      req_q      <= '0;
      reader_sel <= SEL_DMA;
    end else begin
      In_valid <= cpu_gnt || dma_gnt;
      if (cpu_gnt) begin
        req_q      <= cpu_r;
        reader_sel <= SEL_CPU;
      end else if (dma_gnt) begin
        req_q      <= dma_r;
        reader_sel <= SEL_DMA;
      end
    end
  end

  assign WR   = req_q.wr;
  assign Addr = req_q.addr;
  assign Di   = req_q.wdata;

  bram_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_cpu_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cpu_gnt && !cpu_wr),
    .dec  (cpu_rvalid),
    .cnt  (cpu_outst),
    .full (cpu_full)
  );

  bram_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_dma_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (dma_gnt && !dma_wr),
    .dec  (dma_rack),
    .cnt  (dma_outst),
    .full (dma_full)
  );

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(cpu_gnt && dma_gnt));
  a_cpu_cap    : assert property (@(posedge clk) disable iff (rst) cpu_outst <= OUTST_W'(MAX_OUTST));
  a_dma_cap    : assert property (@(posedge clk) disable iff (rst) dma_outst <= OUTST_W'(MAX_OUTST));
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a 10-cycle BRAM controller model
// behind it; expectations follow the BRAM_ARB_RR_EN setting of the build.
module tb_bram_arbiter;
  import bram_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_req, cpu_wr, dma_req, dma_wr;
  logic [ADDR_W-1:0]  cpu_addr, dma_addr, Addr;
  logic [DATA_W-1:0]  cpu_wdata, dma_wdata, Di;
  logic               cpu_gnt, dma_gnt, cpu_rvalid, dma_rack;
  logic               WR, In_valid, reader_sel;
  logic [OUTST_W-1:0] cpu_outst, dma_outst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .cpu_rvalid(cpu_rvalid), .dma_rack(dma_rack),
    .WR(WR), .In_valid(In_valid), .Addr(Addr), .Di(Di), .reader_sel(reader_sel),
    .cpu_outst(cpu_outst), .dma_outst(dma_outst)
  );

  // Controller model: writes land in mem, reads return after 10 cycles on
  // the return line selected by reader_sel. Manual pulses can be OR-ed in.
  logic              model_en = 1'b0;
  logic              man_cpu_rv = 1'b0;
  logic              man_dma_rack = 1'b0;
  logic [31:0]       mem [0:8191];
  logic [9:0]        pv = '0;
  logic [9:0]        ps = '0;
  logic [31:0]       pd [0:9];
  logic [31:0]       Do;

  always @(posedge clk) begin
    if (In_valid && WR) mem[Addr] <= Di;
    pv    <= {pv[8:0], model_en && In_valid && !WR};
    ps    <= {ps[8:0], reader_sel};
    pd[0] <= mem[Addr];
    for (int i = 1; i < 10; i++) pd[i] <= pd[i-1];
  end

  assign Do         = pd[9];
  assign cpu_rvalid = man_cpu_rv | (pv[9] & ps[9]);
  assign dma_rack   = man_dma_rack | (pv[9] & ~ps[9]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    man_cpu_rv = 1'b0; man_dma_rack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic exp_dma;
    logic found;
    int   lat;

    // Reset state, and no grant while reset is held.
    idle();
    rst = 1'b1;
    cpu_req = 1'b1;
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_in_valid", 32'(In_valid), 32'd0);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_addr", 32'(Addr), 32'd0);
    check("rst_di", Di, 32'd0);
    check("rst_reader_sel", 32'(reader_sel), 32'd0);
    check("rst_cpu_outst", 32'(cpu_outst), 32'd0);
    check("rst_dma_outst", 32'(dma_outst), 32'd0);
`ifndef BRAM_ARB_RR_EN
    check("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
`endif
    tick();
    check("rst_in_valid_edge", 32'(In_valid), 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Both read-requesting every cycle.
    cpu_req = 1'b1; dma_req = 1'b1;
    cpu_addr = 13'h0011; dma_addr = 13'h0022;
    for (int i = 0; i < 10; i++) begin
`ifdef BRAM_ARB_RR_EN
      exp_dma = (i % 2 == 1);
`else
      exp_dma = (i % 5 == 4);
`endif
      #1;
      check($sformatf("prio_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(!exp_dma));
      check($sformatf("prio_dma_gnt[%0d]", i), 32'(dma_gnt), 32'(exp_dma));
      tick();
      check($sformatf("prio_in_valid[%0d]", i), 32'(In_valid), 32'd1);
      check($sformatf("prio_sel[%0d]", i), 32'(reader_sel), 32'(!exp_dma));
      @(negedge clk);
    end
`ifdef BRAM_ARB_RR_EN
    check("prio_cpu_outst", 32'(cpu_outst), 32'd5);
    check("prio_dma_outst", 32'(dma_outst), 32'd5);
`else
    check("prio_cpu_outst", 32'(cpu_outst), 32'd8);
    check("prio_dma_outst", 32'(dma_outst), 32'd2);
`endif

    // Nobody requesting: In_valid drops, payload holds the last DMA request.
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    check("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("idle_dma_gnt", 32'(dma_gnt), 32'd0);
    tick();
    check("idle_in_valid", 32'(In_valid), 32'd0);
    check("idle_addr_hold", 32'(Addr), 32'h0022);
    check("idle_sel_hold", 32'(reader_sel), 32'd0);

    // DMA read cap, write bypass, and release by one return.
    do_reset();
    dma_req = 1'b1; dma_addr = 13'h0100;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("cap_gnt[%0d]", i), 32'(dma_gnt), 32'd1);
      @(negedge clk);
    end
    check("cap_outst_full", 32'(dma_outst), 32'd8);
    #1;
    check("cap_gnt_blocked", 32'(dma_gnt), 32'd0);
    tick();
    check("cap_in_valid_low", 32'(In_valid), 32'd0);
    @(negedge clk);
    dma_wr = 1'b1; dma_wdata = 32'h5555_AAAA;
    #1;
    check("cap_write_gnt", 32'(dma_gnt), 32'd1);
    tick();
    check("cap_write_wr", 32'(WR), 32'd1);
    check("cap_write_outst", 32'(dma_outst), 32'd8);
    @(negedge clk);
    dma_req = 1'b0; dma_wr = 1'b0; man_dma_rack = 1'b1;
    tick();
    check("cap_after_rack", 32'(dma_outst), 32'd7);
    @(negedge clk);
    man_dma_rack = 1'b0; dma_req = 1'b1;
    #1;
    check("cap_regrant", 32'(dma_gnt), 32'd1);
    tick();
    check("cap_outst_refull", 32'(dma_outst), 32'd8);
    @(negedge clk);
    idle();

    // Grant-read and return for the same requester in one cycle.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 13'h0007;
    repeat (3) @(negedge clk);
    check("simul_outst_pre", 32'(cpu_outst), 32'd3);
    man_cpu_rv = 1'b1;
    #1;
    check("simul_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    check("simul_outst_same", 32'(cpu_outst), 32'd3);
    @(negedge clk);
    cpu_req = 1'b0;
    tick();
    check("simul_outst_dec", 32'(cpu_outst), 32'd2);
    check("simul_no_underflow", 32'(dut.u_cpu_cnt.err_underflow), 32'd0);
    @(negedge clk);
    idle();

    // Routing through the controller model.
    do_reset();
    model_en = 1'b1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    check("route_wr_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    check("route_wr_wr", 32'(WR), 32'd1);
    check("route_wr_addr", 32'(Addr), 32'h0040);
    check("route_wr_di", Di, 32'hDEAD_BEEF);
    check("route_wr_sel", 32'(reader_sel), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 13'h0040;
    #1;
    check("route_rd_gnt", 32'(dma_gnt), 32'd1);
    tick();
    check("route_rd_wr", 32'(WR), 32'd0);
    check("route_rd_sel", 32'(reader_sel), 32'd0);
    check("route_rd_addr", 32'(Addr), 32'h0040);
    check("route_rd_outst", 32'(dma_outst), 32'd1);
    @(negedge clk);
    dma_req = 1'b0;
    found = 1'b0;
    lat = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (dma_rack) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    check("route_rack_seen", 32'(found), 32'd1);
    check("route_rack_latency", 32'(lat), 32'd10);
    check("route_do", Do, 32'hDEAD_BEEF);
    check("route_no_cpu_rv", 32'(cpu_rvalid), 32'd0);
    tick();
    check("route_outst_done", 32'(dma_outst), 32'd0);
    check("route_cpu_outst", 32'(cpu_outst), 32'd0);
    @(negedge clk);
    model_en = 1'b0;
    idle();

    // Reset in the middle of DMA traffic.
    do_reset();
    dma_req = 1'b1; dma_addr = 13'h0123; dma_wdata = 32'h0000_A5A5;
    repeat (5) @(negedge clk);
    check("mid_outst_pre", 32'(dma_outst), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_in_valid", 32'(In_valid), 32'd0);
    check("mid_wr", 32'(WR), 32'd0);
    check("mid_addr", 32'(Addr), 32'd0);
    check("mid_di", Di, 32'd0);
    check("mid_sel", 32'(reader_sel), 32'd0);
    check("mid_dma_outst", 32'(dma_outst), 32'd0);
    check("mid_cpu_outst", 32'(cpu_outst), 32'd0);
    check("mid_dma_gnt", 32'(dma_gnt), 32'd0);
    tick();
    check("mid_outst_held", 32'(dma_outst), 32'd0);
    @(negedge clk);
    rst = 1'b0; dma_req = 1'b0; man_dma_rack = 1'b1;
    tick();
    check("mid_late_rack_outst", 32'(dma_outst), 32'd0);
    check("mid_err_underflow", 32'(dut.u_dma_cnt.err_underflow), 32'd1);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
